// File: rtl/rlbp_cap_pkg.sv
// Shared register map, field positions and CTRL layout for the RLBP serial capture block.
package rlbp_cap_pkg;

    localparam int unsigned REG_SEL_W = 2;

    localparam logic [REG_SEL_W-1:0] REG_DATA   = 2'd0;
    localparam logic [REG_SEL_W-1:0] REG_STATUS = 2'd1;
    localparam logic [REG_SEL_W-1:0] REG_CTRL   = 2'd2;
    localparam logic [REG_SEL_W-1:0] REG_WCNT   = 2'd3;

    localparam int unsigned ST_LEVEL_LSB = 0;
    localparam int unsigned ST_LEVEL_W   = 6;
    localparam int unsigned ST_EMPTY     = 8;
    localparam int unsigned ST_FULL      = 9;
    localparam int unsigned ST_OVF       = 10;
    localparam int unsigned ST_UDF       = 11;

    localparam int unsigned CTRL_W   = 8;
    localparam int unsigned THRESH_W = 5;
    localparam int unsigned WCNT_W   = 16;

    // CTRL[7:0]: thresh[7:3], irq_en[2], msb_first[1], en[0]
    typedef struct packed {
        logic [THRESH_W-1:0] thresh;
        logic                irq_en;
        logic                msb_first;
        logic                en;
    } ctrl_t;

endpackage

// File: rtl/rlbp_cap_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push when full.
module rlbp_cap_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[PW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Storage carries no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/rlbp_s2p_capture.sv
// Deserializes the RLBP serial stream into words, buffers them and exposes them over Wishbone.
// Optional word counter at offset 0xC is enabled by defining RLBP_CAP_WCNT_EN.
module rlbp_s2p_capture
    import rlbp_cap_pkg::*;
#(
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned DEPTH    = 8,
    parameter logic [3:0]  BASE_NIB = 4'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_data,
    input  logic        s_valid,
    input  logic        s_sof,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq
);

    localparam int unsigned IW = $clog2(WORD_W);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    ctrl_t                 ctrl;
    logic                  ovf;
    logic                  udf;
    logic [IW-1:0]         bit_idx;
    logic [WORD_W-1:0]     shreg;
    logic [WORD_W-1:0]     push_word;
    logic                  push_pend;

    logic                  hit;
    logic [REG_SEL_W-1:0]  reg_sel;
    logic                  wr_en;
    logic                  pop_req;
    logic                  pop;
    logic                  shift_en;
    logic [IW-1:0]         cur_idx;
    logic [IW-1:0]         pos;
    logic                  last_bit;
    logic [WORD_W-1:0]     nxt_word;
    logic [31:0]           rdata;

    logic [WORD_W-1:0]     fifo_dout;
    logic [LW-1:0]         fifo_level;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  unused_ok;

    // A new access is not accepted while the previous ack is still high.
    assign hit      = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB) & ~wbs_ack_o;
    assign reg_sel  = wbs_adr_i[3:2];
    assign wr_en    = hit & wbs_we_i & wbs_sel_i[0];
    assign pop_req  = hit & ~wbs_we_i & (reg_sel == REG_DATA);
    assign pop      = pop_req & ~fifo_empty;
    assign shift_en = ctrl.en & s_valid;

    assign unused_ok = ^{wbs_sel_i[3:1], wbs_adr_i[27:4], wbs_adr_i[1:0],
                         wbs_dat_i[31:12], wbs_dat_i[9:8]};

    always_comb begin
        cur_idx  = s_sof ? '0 : bit_idx;
        pos      = ctrl.msb_first ? (IW'(WORD_W - 1) - cur_idx) : cur_idx;
        last_bit = (cur_idx == IW'(WORD_W - 1));
        nxt_word = shreg;
        nxt_word[pos] = s_data;
    end

    // Deserializer: completed word is presented to the FIFO one cycle after its last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx   <= '0;
            shreg     <= '0;
            push_word <= '0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= shift_en & last_bit;
            if (!ctrl.en) begin
                bit_idx <= '0;
                shreg   <= '0;
            end else if (s_valid) begin
                if (last_bit) begin
                    bit_idx   <= '0;
                    shreg     <= '0;
                    push_word <= nxt_word;
                end else begin
                    bit_idx <= cur_idx + IW'(1);
                    shreg   <= nxt_word;
                end
            end
        end
    end

    rlbp_cap_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_pend),
        .pop   (pop),
        .din   (push_word),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef RLBP_CAP_WCNT_EN
    logic [WCNT_W-1:0] wcnt;

    // Counts only words actually stored; a write to WCNT clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= '0;
        end else if (wr_en && (reg_sel == REG_WCNT)) begin
            wcnt <= '0;
        end else if (push_pend && (!fifo_full || pop) && (wcnt != '1)) begin
            wcnt <= wcnt + WCNT_W'(1);
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!fifo_empty) rdata = 32'(fifo_dout);
            end
            REG_STATUS: begin
                rdata[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
                rdata[ST_EMPTY] = fifo_empty;
                rdata[ST_FULL]  = fifo_full;
                rdata[ST_OVF]   = ovf;
                rdata[ST_UDF]   = udf;
            end
            REG_CTRL: rdata = 32'(ctrl);
            default: begin
`ifdef RLBP_CAP_WCNT_EN
                rdata = 32'(wcnt);
`else
                rdata = '0;
`endif
            end
        endcase
    end

    // Bus response, control/status registers and interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            ctrl      <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            wbs_ack_o <= hit;
            if (hit) wbs_dat_o <= rdata;
            if (wr_en && (reg_sel == REG_CTRL)) ctrl <= ctrl_t'(wbs_dat_i[CTRL_W-1:0]);

            if (push_pend && fifo_full && !pop)
                ovf <= 1'b1;
            else if (wr_en && (reg_sel == REG_STATUS) && wbs_dat_i[ST_OVF])
                ovf <= 1'b0;

            if (pop_req && fifo_empty)
                udf <= 1'b1;
            else if (wr_en && (reg_sel == REG_STATUS) && wbs_dat_i[ST_UDF])
                udf <= 1'b0;

            irq <= ctrl.irq_en && (ctrl.thresh != '0) &&
                   (ST_LEVEL_W'(fifo_level) >= ST_LEVEL_W'(ctrl.thresh));
        end
    end

endmodule

// File: doc/rlbp_s2p_capture.md
Name: rlbp_s2p_capture

Overview:
Downstream consumer of the RLBP core's serial output (serial data + bit strobe). Deserializes the bitstream into WORD_W-bit words and buffers them in a small FIFO. The FIFO is drained by firmware over a Wishbone slave port. Raises an IRQ when the fill level reaches a programmable threshold. Sits beside the RLBP macro in the user area, sharing wb_clk_i / wb_rst_i.

Parameters:
WORD_W, 8, bits per captured word (2..32)
DEPTH, 8, FIFO entries (power of two, 2..32)
BASE_NIB, 4'h4, required value of wbs_adr_i[31:28] for address decode

Ports:
clk  in  1  system clock (wb_clk_i)
rst  in  1  synchronous, active-high reset
s_data  in  1  serial data from RLBP P2S
s_valid  in  1  one-cycle strobe; s_data valid this cycle
s_sof  in  1  start-of-word; qualifies with s_valid, forces bit index to 0
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  address
wbs_dat_i  in  32  write data
wbs_dat_o  out  32  read data
wbs_ack_o  out  1  acknowledge
irq  out  1  level interrupt

Behaviour:
- Reset: wbs_dat_o=0, wbs_ack_o=0, irq=0. FIFO empty, bit index 0, shift reg 0. CTRL=0: capture disabled. OVF/UDF=0.
- Address decode: hit = cyc&stb&(adr[31:28]==BASE_NIB). Register select = adr[3:2].
  - 0x0 DATA (RO): read pops.
  - 0x4 STATUS: [5:0] level, [8] empty, [9] full, [10] OVF sticky, [11] UDF sticky; W1C on [11:10].
  - 0x8 CTRL (RW): [0] en, [1] msb_first, [2] irq_en, [7:3] thresh.
  - 0xC WCNT.
- Writes need wbs_sel_i[0]; otherwise ignored.
- Wishbone timing: ack asserted exactly one cycle after a hit, for one cycle only. No new access is accepted while ack=1, so back-to-back accesses take 2 cycles each. wbs_dat_o is registered with ack; non-hit cycles hold the previous value.
- Deserializer (active only when en=1; s_valid ignored when en=0):
  - Each s_valid shifts s_data in. If s_sof=1, the bit is index 0 and any partial word is discarded.
  - msb_first=1: first bit lands in word[WORD_W-1]; msb_first=0: first bit lands in word[0].
  - On the bit with index WORD_W-1, the word completes and is pushed the next cycle; index wraps to 0.
  - Clearing en discards the partial word and resets the index to 0.
- FIFO:
  - Push when full: word dropped, OVF=1.
  - DATA read when empty: returns 0, no pointer move, UDF=1.
  - Pop returns the head word zero-extended to 32 bits. The pop takes effect in the ack cycle.
  - Push and pop in the same cycle when full: both succeed, level unchanged, no OVF.
  - Push and pop in the same cycle when empty: the pop sees empty (UDF); the push is stored.
- Level rules: level 0..DEPTH. Pointers are log2(DEPTH)+1 bits with a wrap bit; full when the low bits are equal and the wrap bits differ.
- irq = irq_en & (level >= thresh) & (thresh != 0). Registered, updates one cycle after the level changes.
- Reset mid-word or mid-transaction: everything returns to reset state next cycle; ack is dropped.

Optional Feature:
Macro RLBP_CAP_WCNT_EN.
- Defined: 16-bit counter of words pushed, saturating at 0xFFFF, readable at 0xC. Any write to 0xC clears it. Dropped (overflow) words are not counted.
- Undefined: 0xC reads 0, writes ignored, no counter flops.

Decomposition:
- Package rlbp_cap_pkg: register offsets, STATUS/CTRL bit positions, field widths.
- Sub-module rlbp_cap_fifo: a synchronous FIFO parameterised by WIDTH and DEPTH, with push, pop, dout, level, full and empty. Kept separate so it can be reused for other buffers in the user area.

Test Plan:
- en=1, msb_first=1, WORD_W=8: send bits 1,0,1,1,0,0,1,0 with s_sof on the first -> STATUS level=1; DATA read = 0x000000B2; then level=0, empty=1.
- Same bits with msb_first=0 -> DATA = 0x0000004D.
- Push 9 words with DEPTH=8 -> full=1, OVF=1, level=8. First DATA read returns word 0. Write 0x400 to STATUS -> OVF=0.
- Read DATA with FIFO empty -> 0x0, ack one cycle after stb, UDF=1. Level stays 0.
- thresh=3, irq_en=1: push 3 words -> irq=1 one cycle after the third push. One pop -> irq=0.
- Send 5 bits, then s_sof with a new byte 0xFF -> only 0xFF is stored. Assert rst mid-word -> level=0, ack=0, CTRL=0.
